// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for seq_alu.
// No ports: constants, types and one decode helper.
package alu_pkg;

  typedef logic [3:0] opcode_t;
  typedef logic [1:0] state_t;

  localparam opcode_t OP_AND  = 4'd0;
  localparam opcode_t OP_OR   = 4'd1;
  localparam opcode_t OP_ADD  = 4'd2;
  localparam opcode_t OP_SUB  = 4'd3;
  localparam opcode_t OP_SLT  = 4'd4;
  localparam opcode_t OP_SLTU = 4'd5;
  localparam opcode_t OP_XOR  = 4'd6;
  localparam opcode_t OP_NOR  = 4'd7;
  localparam opcode_t OP_SLL  = 4'd8;
  localparam opcode_t OP_SRL  = 4'd9;
  localparam opcode_t OP_SRA  = 4'd10;
  localparam opcode_t OP_MUL  = 4'd11;
  localparam opcode_t OP_DIVU = 4'd12;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_muldiv(
    input opcode_t op
  );
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Ports: clk, reset, i_start/i_op/i_a/i_b load; o_done marks
// the last iteration, o_lo/o_hi carry that iteration's result.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  opcode_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_done
);

  // r_acc: product high / remainder
  // r_q:   multiplier bits / quotient
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_tmp;
  logic [WIDTH:0]   w_shl;
  logic             w_ge;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_q_nx;
  logic             w_last;

  always_comb begin
    w_sum    = {1'b0, r_acc} + {1'b0, r_b};
    w_tmp    = {1'b0, r_acc};
    w_shl    = {r_acc, r_q[WIDTH-1]};
    w_ge     = w_shl >= {1'b0, r_b};
    w_dif    = w_shl[WIDTH-1:0] - r_b;
    w_acc_nx = r_acc;
    w_q_nx   = r_q;
    if (r_div) begin
      // b == 0 always subtracts: quotient all
      // ones, remainder collects the dividend
      w_q_nx = {r_q[WIDTH-2:0], w_ge};
      if (w_ge) begin
        w_acc_nx = w_dif;
      end else begin
        w_acc_nx = w_shl[WIDTH-1:0];
      end
    end else begin
      if (r_q[0]) begin
        w_tmp = w_sum;
      end
      w_acc_nx = w_tmp[WIDTH:1];
      w_q_nx   = {w_tmp[0], r_q[WIDTH-1:1]};
    end
  end

  assign w_last = r_run &&
    (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
      r_div <= (i_op == OP_DIVU);
      r_run <= 1'b1;
      r_cnt <= '0;
    end else if (r_run) begin
      r_acc <= w_acc_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

  assign o_lo   = w_q_nx;
  assign o_hi   = w_acc_nx;
  assign o_done = w_last;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus
// iterative MUL/DIVU. Ports: clk, reset, start, control,
// in1, in2 in; out, out_hi, zero, overflow, busy, done out.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;

  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_lt;
  logic             w_ltu;
  logic [CNT_W-2:0] w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_md_start;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
  logic             w_md_done;

  // SUB reuses the adder as A + ~B + 1
  assign w_sub = (control == OP_SUB);
  assign w_bx  = w_sub ? ~in2 : in2;
  assign w_sum = in1 + w_bx +
    {{(WIDTH-1){1'b0}}, w_sub};
  assign w_ovf =
    ((control == OP_ADD) || w_sub) &&
    (in1[WIDTH-1] == w_bx[WIDTH-1]) &&
    (w_sum[WIDTH-1] != in1[WIDTH-1]);

  assign w_lt  = $signed(in1) < $signed(in2);
  assign w_ltu = in1 < in2;
  assign w_sh  = in2[CNT_W-2:0];

  always_comb begin
    w_res = '0;
    case (control)
      OP_AND:  w_res = in1 & in2;
      OP_OR:   w_res = in1 | in2;
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_sum;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_ltu};
      OP_XOR:  w_res = in1 ^ in2;
      OP_NOR:  w_res = ~(in1 | in2);
      OP_SLL:  w_res = in1 << w_sh;
      OP_SRL:  w_res = in1 >> w_sh;
      OP_SRA:  w_res = $unsigned(
                 $signed(in1) >>> w_sh);
      default: w_res = '0;
    endcase
  end

  assign w_md_start = (r_state == ST_IDLE) &&
    start && is_muldiv(control);

  alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_md_start),
    .i_op    (control),
    .i_a     (in1),
    .i_b     (in2),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi),
    .o_done  (w_md_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_hi    <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (is_muldiv(control)) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_out   <= w_res;
              r_hi    <= '0;
              r_zero  <= (w_res == '0);
              r_ovf   <= w_ovf;
            end
          end
        end
        ST_RUN: begin
          // result lands with the final iteration
          if (w_md_done) begin
            r_state <= ST_DONE;
            r_out   <= w_md_lo;
            r_hi    <= w_md_hi;
            r_zero  <= (w_md_lo == '0);
            r_ovf   <= 1'b0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out      = r_out;
  assign out_hi   = r_hi;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
// Expected results queued at issue, popped on done.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, start8;
  logic [3:0]  ctrl32, ctrl8;
  logic [31:0] a32, b32, out32, hi32;
  logic [7:0]  a8, b8, out8, hi8;
  logic        zero32, ovf32, busy32, done32;
  logic        zero8, ovf8, busy8, done8;

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32),
    .control(ctrl32), .in1(a32), .in2(b32),
    .out(out32), .out_hi(hi32), .zero(zero32),
    .overflow(ovf32), .busy(busy32), .done(done32)
  );

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8),
    .control(ctrl8), .in1(a8), .in2(b8),
    .out(out8), .out_hi(hi8), .zero(zero8),
    .overflow(ovf8), .busy(busy8), .done(done8)
  );

  typedef struct {
    string       tag;
    logic [63:0] o;
    logic [63:0] hi;
    logic        z;
    logic        v;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag,
    input logic [63:0] o, input logic [63:0] hi,
    input logic z, input logic v);
    exp_t e;
    e.tag = tag; e.o = o; e.hi = hi;
    e.z = z; e.v = v;
    return e;
  endfunction

  function automatic longint sx(input int w,
                                input logic [63:0] v);
    if (v[w-1]) return longint'(v) - (longint'(1) <<< w);
    return longint'(v);
  endfunction

  function automatic exp_t model(input int w,
    input string tag, input logic [3:0] op,
    input logic [63:0] ai, input logic [63:0] bi);
    exp_t e;
    logic [63:0] m, a, b, p;
    longint sa, sb, s, mx, mn;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    a  = ai & m;
    b  = bi & m;
    sa = sx(w, a);
    sb = sx(w, b);
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    sh = int'(b & 64'(w - 1));
    e.tag = tag; e.o = 0; e.hi = 0; e.v = 0;
    case (op)
      4'd0: e.o = a & b;
      4'd1: e.o = a | b;
      4'd2: begin
        s = sa + sb; e.o = 64'(s) & m;
        e.v = (s > mx) || (s < mn);
      end
      4'd3: begin
        s = sa - sb; e.o = 64'(s) & m;
        e.v = (s > mx) || (s < mn);
      end
      4'd4: e.o = (sa < sb) ? 64'd1 : 64'd0;
      4'd5: e.o = (a < b) ? 64'd1 : 64'd0;
      4'd6: e.o = a ^ b;
      4'd7: e.o = ~(a | b) & m;
      4'd8: e.o = (a << sh) & m;
      4'd9: e.o = a >> sh;
      4'd10: e.o = 64'(sa >>> sh) & m;
      4'd11: begin
        p = a * b; e.o = p & m; e.hi = p >> w;
      end
      4'd12: begin
        if (b == 0) begin e.o = m; e.hi = a; end
        else begin e.o = a / b; e.hi = a % b; end
      end
      default: e.o = 0;
    endcase
    e.z = (e.o == 0);
    return e;
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset && done32) begin
      if (q32.size() == 0) begin
        chk("spurious_done32", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk({e.tag, ".out"}, 64'(out32), e.o);
        chk({e.tag, ".hi"}, 64'(hi32), e.hi);
        chk({e.tag, ".zero"}, 64'(zero32), 64'(e.z));
        chk({e.tag, ".ovf"}, 64'(ovf32), 64'(e.v));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        chk("spurious_done8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        chk({e.tag, ".out"}, 64'(out8), e.o);
        chk({e.tag, ".hi"}, 64'(hi8), e.hi);
        chk({e.tag, ".zero"}, 64'(zero8), 64'(e.z));
        chk({e.tag, ".ovf"}, 64'(ovf8), 64'(e.v));
      end
    end
  end

  // issue one op, count edges until done, then
  // let the FSM fall back to IDLE
  task automatic go(input bit w8,
    input logic [3:0] op, input logic [63:0] a,
    input logic [63:0] b, input exp_t e,
    input int lat, input bit poke);
    int k;
    bit got;
    @(negedge clk);
    if (w8) begin
      ctrl8 = op; a8 = a[7:0]; b8 = b[7:0];
      start8 = 1'b1; q8.push_back(e);
    end else begin
      ctrl32 = op; a32 = a[31:0]; b32 = b[31:0];
      start32 = 1'b1; q32.push_back(e);
    end
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (w8) begin
        start8 = 1'b0;
      end else begin
        start32 = poke && (k == 3 || k == 12);
        if (poke && k == 3) begin
          ctrl32 = 4'd0; a32 = $urandom; b32 = $urandom;
        end
      end
      if (k == 10 && lat > 1)
        chk({e.tag, ".busy"},
            64'(w8 ? busy8 : busy32), 64'd1);
      got = w8 ? done8 : done32;
    end
    start8 = 1'b0;
    start32 = 1'b0;
    chk({e.tag, ".lat"}, 64'(k), 64'(lat));
    @(posedge clk); #1;
    chk({e.tag, ".idle"},
        64'(w8 ? busy8 : busy32), 64'd0);
  endtask

  initial begin : main
    int nd;
    bit w8;
    int w;
    logic [3:0] op;
    logic [63:0] a, b;
    reset = 1'b1;
    start32 = 0; start8 = 0;
    ctrl32 = 0; ctrl8 = 0;
    a32 = 0; b32 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out", 64'(out32), 64'd0);
    chk("rst.hi", 64'(hi32), 64'd0);
    chk("rst.zero", 64'(zero32), 64'd1);
    chk("rst.ovf", 64'(ovf32), 64'd0);
    chk("rst.busy", 64'(busy32), 64'd0);
    chk("rst.done", 64'(done32), 64'd0);
    chk("rst8.zero", 64'(zero8), 64'd1);
    reset = 1'b0;

    go(0, 4'd2, 64'h7FFFFFFF, 64'd1,
       mk("add_ovf", 64'h80000000, 0, 0, 1), 1, 0);
    go(0, 4'd3, 64'd12, 64'd12,
       mk("sub_zero", 0, 0, 1, 0), 1, 0);
    go(0, 4'd3, 64'h80000000, 64'd1,
       mk("sub_ovf", 64'h7FFFFFFF, 0, 0, 1), 1, 0);
    go(0, 4'd4, 64'hFFFFFFFF, 64'd1,
       mk("slt", 1, 0, 0, 0), 1, 0);
    go(0, 4'd5, 64'hFFFFFFFF, 64'd1,
       mk("sltu", 0, 0, 1, 0), 1, 0);
    go(0, 4'd13, 64'd5, 64'd6,
       mk("op13", 0, 0, 1, 0), 1, 0);
    go(0, 4'd11, 64'hFFFFFFFF, 64'd2,
       mk("mul", 64'hFFFFFFFE, 1, 0, 0), 33, 1);
    go(0, 4'd12, 64'd100, 64'd0,
       mk("div0", 64'hFFFFFFFF, 100, 0, 0), 33, 1);
    go(0, 4'd12, 64'd100, 64'd7,
       mk("divu", 14, 2, 0, 0), 33, 0);
    go(1, 4'd10, 64'h80, 64'd3,
       mk("sra8", 64'hF0, 0, 0, 0), 1, 0);
    go(1, 4'd8, 64'h01, 64'd7,
       mk("sll8", 64'h80, 0, 0, 0), 1, 0);
    go(1, 4'd11, 64'hFF, 64'hFF,
       mk("mul8", 64'h01, 64'hFE, 0, 0), 9, 0);
    go(1, 4'd12, 64'd200, 64'd9,
       mk("divu8", 22, 2, 0, 0), 9, 0);

    // reset ten cycles into a MUL, with start held
    @(negedge clk);
    ctrl32 = 4'd11; a32 = 32'h1234; b32 = 32'h55;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    ctrl32 = 4'd2; start32 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start32 = 1'b0;
    chk("abort.busy", 64'(busy32), 64'd0);
    chk("abort.out", 64'(out32), 64'd0);
    chk("abort.zero", 64'(zero32), 64'd1);
    chk("abort.done", 64'(done32), 64'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) nd++;
    end
    chk("abort.nodone", 64'(nd), 64'd0);

    for (int i = 0; i < 16; i++) begin
      w8 = i[0];
      w  = w8 ? 8 : 32;
      op = 4'($urandom_range(0, 15));
      a  = {32'd0, $urandom};
      b  = {32'd0, $urandom};
      if (i % 4 == 2) b = b & 64'h3;
      go(w8, op, a, b,
         model(w, $sformatf("rnd%0d", i), op, a, b),
         (op == 4'd11 || op == 4'd12) ? w + 1 : 1,
         !w8 && (op == 4'd11 || op == 4'd12));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q32.empty", 64'(q32.size()), 64'd0);
    chk("q8.empty", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-006 SHALL have port control, input, 4, opcode, captured with start.
REQ-007 SHALL have port in1, input, WIDTH, operand A, captured with start.
REQ-008 SHALL have port in2, input, WIDTH, operand B, captured with start.
REQ-009 SHALL have port out, output, WIDTH, registered primary result.
REQ-010 SHALL have port out_hi, output, WIDTH, registered high product (MUL) or remainder (DIVU), else 0.
REQ-011 SHALL have port zero, output, 1, high when out == 0, updated with out.
REQ-012 SHALL have port overflow, output, 1, signed overflow for ADD/SUB, else 0.
REQ-013 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse when out/out_hi/zero/overflow are valid.

Function
REQ-015 SHALL decode opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 SLTU, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 MUL (unsigned), 12 DIVU; 13-15 produce out=0, done still pulses.
REQ-016 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start for MUL/DIVU, IDLE->DONE on start otherwise, RUN->DONE when counter reaches WIDTH, DONE->IDLE unconditionally.
REQ-017 SHALL give single-cycle ops a latency of 1: start at edge N, done high during cycle after edge N+1... i.e. done asserted exactly one cycle after acceptance.
REQ-018 SHALL give MUL/DIVU latency WIDTH+1 cycles from acceptance to done, one shift-add/restoring-subtract iteration per RUN cycle.
REQ-019 SHALL ignore start while busy; operands/opcode SHALL not change mid-operation.
REQ-020 SHALL hold out/out_hi/zero/overflow stable after done until the next done.
REQ-021 SHALL take shift amount from in2[CNT_W-2:0]; amounts >= WIDTH not reachable by construction.
REQ-022 SHALL compute ADD/SUB modulo 2^WIDTH; overflow = sign(A)==sign(B') && sign(result)!=sign(A), B' = B or ~B.
REQ-023 SHALL, for DIVU with in2 == 0, return out = all ones, out_hi = in1, still after WIDTH+1 cycles.
REQ-024 SHALL return MUL low half in out, high half in out_hi.
REQ-025 SHALL accept a new start in the cycle done is high only after return to IDLE (back-to-back throughput one op per 2 cycles for single-cycle ops).

Reset
REQ-026 SHALL, on reset high at a clock edge, force state IDLE, out=0, out_hi=0, zero=1, overflow=0, busy=0, done=0, counter=0.
REQ-027 SHALL abort any RUN operation on reset with no done pulse; reset overrides simultaneous start.

Structure
REQ-028 SHALL place opcode constants and FSM state encodings in shared package alu_pkg.
REQ-029 SHALL implement the iterative multiplier/divider as sub-module alu_muldiv (WIDTH parameter, start/done handshake).

Verification
REQ-030 ADD in1=0x7FFFFFFF, in2=1 -> out=0x80000000, overflow=1, zero=0, done one cycle after start.
REQ-031 SUB in1=12, in2=12 -> out=0, zero=1; SLT in1=-1, in2=1 -> out=1; SLTU same operands -> out=0.
REQ-032 MUL in1=0xFFFFFFFF, in2=2 -> out=0xFFFFFFFE, out_hi=1, done exactly 33 cycles after start; start pulses during busy ignored.
REQ-033 DIVU in1=100, in2=7 -> out=14, out_hi=2; DIVU in2=0 -> out=0xFFFFFFFF, out_hi=100.
REQ-034 Reset asserted mid-MUL (cycle 10) -> next cycle busy=0, out=0, zero=1, no done pulse.
REQ-035 WIDTH=8 build: SRA in1=0x80, in2=3 -> out=0xF0; SLL in1=0x01, in2=7 -> out=0x80.
